// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the forwarding / hazard unit.
package fwd_hazard_unit_pkg;

    localparam int unsigned WB_SEL_W    = 3;
    localparam int unsigned MAX_DATA_W  = 64;

    // Writeback data source selected by the WB stage
    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU = 3'd0,
        WB_MEM = 3'd1,
        WB_IH  = 3'd2,
        WB_PC  = 3'd3,
        WB_NOP = 3'd4
    } wb_data_op_e;

    // Special register addresses in the shared encoding (R0-R7 occupy 0-7)
    localparam logic [3:0] REG_IH = 4'd8;
    localparam logic [3:0] REG_SP = 4'd9;
    localparam logic [3:0] REG_T  = 4'd10;

    localparam logic FORWARD_ENABLE  = 1'b1;
    localparam logic FORWARD_DISABLE = 1'b0;

    localparam logic [MAX_DATA_W-1:0] EMPTY_DATA = '0;

    // Memory-wait handshake states
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_TOUT = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port bypass priority mux: EX/MEM > MEM/WB > WB echo > register file.
module fwd_port_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 4
) (
    input  logic               rd_valid,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               emo_live,
    input  logic               emo_is_load,
    input  logic [RADDR_W-1:0] emo_addr,
    input  logic [DATA_W-1:0]  emo_val,
    input  logic               mwo_live,
    input  logic [RADDR_W-1:0] mwo_addr,
    input  logic [DATA_W-1:0]  mwo_val,
    input  logic               echo_valid,
    input  logic [RADDR_W-1:0] echo_addr,
    input  logic [DATA_W-1:0]  echo_data,
    output logic               fwd_en_c,
    output logic [DATA_W-1:0]  fwd_data_c,
    output logic               load_use_c
);

    // Youngest matching producer wins; a load in EX/MEM cannot be bypassed yet
    always_comb begin
        fwd_en_c   = FORWARD_DISABLE;
        fwd_data_c = DATA_W'(EMPTY_DATA);
        load_use_c = 1'b0;
        if (rd_valid) begin
            if (emo_live && (emo_addr == rd_addr)) begin
                if (emo_is_load) begin
                    load_use_c = 1'b1;
                end else begin
                    fwd_en_c   = FORWARD_ENABLE;
                    fwd_data_c = emo_val;
                end
            end else if (mwo_live && (mwo_addr == rd_addr)) begin
                fwd_en_c   = FORWARD_ENABLE;
                fwd_data_c = mwo_val;
            end else if (echo_valid && (echo_addr == rd_addr)) begin
                fwd_en_c   = FORWARD_ENABLE;
                fwd_data_c = echo_data;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use stall and memory-wait hold control for the EX stage.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RADDR_W     = 4,
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned MAX_WAIT    = 15,
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*RADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]           rd_valid,
    input  logic                        emo_wb_en,
    input  logic [RADDR_W-1:0]          emo_wb_addr,
    input  logic [WB_SEL_W-1:0]         emo_wb_sel,
    input  logic [DATA_W-1:0]           emo_alu,
    input  logic [DATA_W-1:0]           emo_ih,
    input  logic [DATA_W-1:0]           emo_pc,
    input  logic                        emo_mem_req,
    input  logic                        mem_ready,
    input  logic                        mwo_wb_en,
    input  logic [RADDR_W-1:0]          mwo_wb_addr,
    input  logic [WB_SEL_W-1:0]         mwo_wb_sel,
    input  logic [DATA_W-1:0]           mwo_alu,
    input  logic [DATA_W-1:0]           mwo_ih,
    input  logic [DATA_W-1:0]           mwo_pc,
    input  logic [DATA_W-1:0]           mwo_ram,
    output logic [NUM_RD*DATA_W-1:0]    fwd_data,
    output logic [NUM_RD-1:0]           fwd_en,
    output logic                        hold_front,
    output logic                        bubble_mem,
    output logic                        hold_all,
    output logic                        wait_timeout,
    output logic [15:0]                 stall_cycles
);

    localparam int unsigned CNT_W   = $clog2(MAX_WAIT + 1);
    localparam int unsigned STALL_W = 16;

    fsm_state_e          state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                echo_valid_q, echo_valid_d;
    logic [RADDR_W-1:0]  echo_addr_q, echo_addr_d;
    logic [DATA_W-1:0]   echo_data_q, echo_data_d;
    logic                wait_timeout_q, wait_timeout_d;
    logic [STALL_W-1:0]  stall_q, stall_d;

    logic [DATA_W-1:0]   emo_val, mwo_val;
    logic                emo_live, mwo_live, emo_is_load;
    logic [NUM_RD-1:0]   load_use_vec;
    logic                load_use;
    logic                hold_all_c;

    // Candidate values from each pipeline stage according to its WB selector
    always_comb begin
        emo_val = DATA_W'(EMPTY_DATA);
        mwo_val = DATA_W'(EMPTY_DATA);
        case (emo_wb_sel)
            WB_ALU:  emo_val = emo_alu;
            WB_IH:   emo_val = emo_ih;
            WB_PC:   emo_val = emo_pc;
            default: emo_val = DATA_W'(EMPTY_DATA);
        endcase
        case (mwo_wb_sel)
            WB_ALU:  mwo_val = mwo_alu;
            WB_MEM:  mwo_val = mwo_ram;
            WB_IH:   mwo_val = mwo_ih;
            WB_PC:   mwo_val = mwo_pc;
            default: mwo_val = DATA_W'(EMPTY_DATA);
        endcase
    end

    // A stage is a valid bypass source only if it really writes a register
    always_comb begin
        emo_live    = emo_wb_en && (emo_wb_sel != WB_NOP) &&
                      ((ZERO_REG_EN == 0) || (emo_wb_addr != '0));
        mwo_live    = mwo_wb_en && (mwo_wb_sel != WB_NOP) &&
                      ((ZERO_REG_EN == 0) || (mwo_wb_addr != '0));
        emo_is_load = (emo_wb_sel == WB_MEM);
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        fwd_port_sel #(
            .DATA_W  (DATA_W),
            .RADDR_W (RADDR_W)
        ) u_port_sel (
            .rd_valid    (rd_valid[i] & rst),
            .rd_addr     (rd_addr[i*RADDR_W +: RADDR_W]),
            .emo_live    (emo_live),
            .emo_is_load (emo_is_load),
            .emo_addr    (emo_wb_addr),
            .emo_val     (emo_val),
            .mwo_live    (mwo_live),
            .mwo_addr    (mwo_wb_addr),
            .mwo_val     (mwo_val),
            .echo_valid  (echo_valid_q),
            .echo_addr   (echo_addr_q),
            .echo_data   (echo_data_q),
            .fwd_en_c    (fwd_en[i]),
            .fwd_data_c  (fwd_data[i*DATA_W +: DATA_W]),
            .load_use_c  (load_use_vec[i])
        );
    end

    // Memory-wait handshake: hold everything until ready or the wait budget runs out
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hold_all_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (emo_mem_req && !mem_ready) begin
                    hold_all_c = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    hold_all_c = 1'b1;
                    if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
                        state_d    = ST_TOUT;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TOUT: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Pipeline controls; all released while reset is asserted
    always_comb begin
        load_use   = |load_use_vec;
        hold_all   = hold_all_c & rst;
        hold_front = load_use & ~hold_all;
        bubble_mem = hold_front;
    end

    // Next values for the WB echo, timeout flag and stall counter
    always_comb begin
        echo_valid_d   = echo_valid_q;
        echo_addr_d    = echo_addr_q;
        echo_data_d    = echo_data_q;
        wait_timeout_d = wait_timeout_q | (state_d == ST_TOUT);
        stall_d        = stall_q;
        if (!hold_all) begin
            echo_valid_d = mwo_live;
            echo_addr_d  = mwo_wb_addr;
            echo_data_d  = mwo_val;
        end
        if ((hold_front || hold_all) && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            echo_valid_q   <= 1'b0;
            echo_addr_q    <= '0;
            echo_data_q    <= '0;
            wait_timeout_q <= 1'b0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            echo_valid_q   <= echo_valid_d;
            echo_addr_q    <= echo_addr_d;
            echo_data_q    <= echo_data_d;
            wait_timeout_q <= wait_timeout_d;
            stall_q        <= stall_d;
        end
    end

    assign wait_timeout = wait_timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [1:0]  rd_valid;
    logic        emo_wb_en;
    logic [3:0]  emo_wb_addr;
    logic [2:0]  emo_wb_sel;
    logic [15:0] emo_alu, emo_ih, emo_pc;
    logic        emo_mem_req;
    logic        mem_ready;
    logic        mwo_wb_en;
    logic [3:0]  mwo_wb_addr;
    logic [2:0]  mwo_wb_sel;
    logic [15:0] mwo_alu, mwo_ih, mwo_pc, mwo_ram;
    logic [31:0] fwd_data;
    logic [1:0]  fwd_en;
    logic        hold_front, bubble_mem, hold_all, wait_timeout;
    logic [15:0] stall_cycles;

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .emo_wb_en    (emo_wb_en),
        .emo_wb_addr  (emo_wb_addr),
        .emo_wb_sel   (emo_wb_sel),
        .emo_alu      (emo_alu),
        .emo_ih       (emo_ih),
        .emo_pc       (emo_pc),
        .emo_mem_req  (emo_mem_req),
        .mem_ready    (mem_ready),
        .mwo_wb_en    (mwo_wb_en),
        .mwo_wb_addr  (mwo_wb_addr),
        .mwo_wb_sel   (mwo_wb_sel),
        .mwo_alu      (mwo_alu),
        .mwo_ih       (mwo_ih),
        .mwo_pc       (mwo_pc),
        .mwo_ram      (mwo_ram),
        .fwd_data     (fwd_data),
        .fwd_en       (fwd_en),
        .hold_front   (hold_front),
        .bubble_mem   (bubble_mem),
        .hold_all     (hold_all),
        .wait_timeout (wait_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  en;
        logic [31:0] data;
        logic        hf;
        logic        ha;
        logic        to;
        logic [15:0] st;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [53:0] act_v, req_v;

    task automatic expect_o(input string nm, input logic [1:0] en, input logic [31:0] d,
                            input logic hf, input logic ha, input logic to, input logic [15:0] st);
        exp_t e;
        e.name = nm; e.en = en; e.data = d; e.hf = hf; e.ha = ha; e.to = to; e.st = st;
        sb_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_valid = 2'b00; rd_addr = 8'h00;
        emo_wb_en = 1'b0; emo_wb_addr = 4'd0; emo_wb_sel = WB_NOP;
        emo_alu = 16'h0; emo_ih = 16'h0; emo_pc = 16'h0;
        emo_mem_req = 1'b0; mem_ready = 1'b1;
        mwo_wb_en = 1'b0; mwo_wb_addr = 4'd0; mwo_wb_sel = WB_NOP;
        mwo_alu = 16'h0; mwo_ih = 16'h0; mwo_pc = 16'h0; mwo_ram = 16'h0;
    endtask

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            act_v = {fwd_en, fwd_data, hold_front, bubble_mem, hold_all, wait_timeout, stall_cycles};
            req_v = {mon_e.en, mon_e.data, mon_e.hf, mon_e.hf, mon_e.ha, mon_e.to, mon_e.st};
            if (act_v !== req_v) begin
                n_fail++;
                $display("FAIL %s: got en=%b data=%h hf=%b bm=%b ha=%b to=%b st=%0d ; want en=%b data=%h hf=%b bm=%b ha=%b to=%b st=%0d",
                         mon_e.name, fwd_en, fwd_data, hold_front, bubble_mem, hold_all, wait_timeout, stall_cycles,
                         mon_e.en, mon_e.data, mon_e.hf, mon_e.hf, mon_e.ha, mon_e.to, mon_e.st);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle();

        // Reset: even a live match and a pending memory stall must stay released
        next_cyc();
        rd_valid = 2'b11; rd_addr = {4'd3, 4'd3};
        emo_wb_en = 1'b1; emo_wb_addr = 4'd3; emo_wb_sel = WB_ALU; emo_alu = 16'h1234;
        emo_mem_req = 1'b1; mem_ready = 1'b0;
        expect_o("reset_state", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);

        next_cyc();
        rst = 1'b1; idle();
        expect_o("post_reset_idle", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);

        // EX/MEM ALU forward to port 0
        next_cyc(); idle();
        emo_wb_en = 1'b1; emo_wb_addr = 4'd3; emo_wb_sel = WB_ALU; emo_alu = 16'h1234;
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd3};
        expect_o("emo_alu_p0", 2'b01, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 16'd0);

        // EX/MEM beats MEM/WB on the same address
        next_cyc(); idle();
        emo_wb_en = 1'b1; emo_wb_addr = 4'd3; emo_wb_sel = WB_ALU; emo_alu = 16'hAAAA;
        mwo_wb_en = 1'b1; mwo_wb_addr = 4'd3; mwo_wb_sel = WB_ALU; mwo_alu = 16'h5555;
        rd_valid = 2'b10; rd_addr = {4'd3, 4'd0};
        expect_o("youngest_wins_p1", 2'b10, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0, 16'd0);

        // Load-use on R5
        next_cyc(); idle();
        emo_wb_en = 1'b1; emo_wb_addr = 4'd5; emo_wb_sel = WB_MEM;
        emo_mem_req = 1'b1; mem_ready = 1'b1;
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd5};
        expect_o("load_use_stall", 2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);

        // Load data now in MEM/WB
        next_cyc(); idle();
        mwo_wb_en = 1'b1; mwo_wb_addr = 4'd5; mwo_wb_sel = WB_MEM; mwo_ram = 16'hBEEF;
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd5};
        expect_o("load_use_resolved", 2'b01, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 16'd1);

        // MEM/WB writes SP, nobody reads it yet
        next_cyc(); idle();
        mwo_wb_en = 1'b1; mwo_wb_addr = REG_SP; mwo_wb_sel = WB_ALU; mwo_alu = 16'h00F0;
        expect_o("sp_write_no_read", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 16'd1);

        // SP now only available through the echo; MEM/WB writes R2 meanwhile
        next_cyc(); idle();
        mwo_wb_en = 1'b1; mwo_wb_addr = 4'd2; mwo_wb_sel = WB_ALU; mwo_alu = 16'h2222;
        rd_valid = 2'b01; rd_addr = {4'd0, REG_SP};
        expect_o("echo_sp", 2'b01, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 16'd1);

        // Memory wait 3 cycles; load-use on R6 is masked by hold_all; echo must freeze on R2
        for (int i = 0; i < 3; i++) begin
            next_cyc(); idle();
            emo_wb_en = 1'b1; emo_wb_addr = 4'd6; emo_wb_sel = WB_MEM;
            emo_mem_req = 1'b1; mem_ready = 1'b0;
            mwo_wb_en = 1'b1; mwo_wb_addr = 4'd7; mwo_wb_sel = WB_ALU; mwo_alu = 16'h7777;
            rd_valid = 2'b01; rd_addr = {4'd0, 4'd6};
            expect_o("mem_wait_hold", 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 16'(1 + i));
        end

        // Release: R7 never reached the echo, R2 still there
        next_cyc(); idle();
        emo_wb_en = 1'b1; emo_wb_addr = 4'd6; emo_wb_sel = WB_MEM;
        emo_mem_req = 1'b1; mem_ready = 1'b1;
        rd_valid = 2'b11; rd_addr = {4'd2, 4'd7};
        expect_o("mem_release_echo_frozen", 2'b10, 32'h2222_0000, 1'b0, 1'b0, 1'b0, 16'd4);

        // IH from EX/MEM and PC from MEM/WB
        next_cyc(); idle();
        emo_wb_en = 1'b1; emo_wb_addr = REG_IH; emo_wb_sel = WB_IH; emo_ih = 16'h1111; emo_alu = 16'hDEAD;
        mwo_wb_en = 1'b1; mwo_wb_addr = REG_T; mwo_wb_sel = WB_PC; mwo_pc = 16'h2222; mwo_ram = 16'h9999;
        rd_valid = 2'b11; rd_addr = {REG_IH, REG_T};
        expect_o("ih_pc_sources", 2'b11, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 16'd4);

        // Timeout: one RUN cycle plus MAX_WAIT WAIT cycles of hold, then TOUT
        next_cyc(); idle();
        emo_mem_req = 1'b1; mem_ready = 1'b0;
        expect_o("tout_first_hold", 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 16'd4);
        for (int i = 1; i <= 15; i++) begin
            next_cyc();
            expect_o("tout_wait_hold", 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 16'(4 + i));
        end
        next_cyc();
        expect_o("tout_state", 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 16'd20);
        next_cyc(); idle();
        expect_o("tout_sticky_1", 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 16'd20);
        next_cyc(); idle();
        expect_o("tout_sticky_2", 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 16'd20);

        // New wait, then async reset mid-WAIT
        next_cyc(); idle();
        emo_mem_req = 1'b1; mem_ready = 1'b0;
        expect_o("wait_again_run", 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 16'd20);
        next_cyc();
        expect_o("wait_again_wait", 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 16'd21);
        next_cyc();
        rst = 1'b0;
        emo_wb_en = 1'b1; emo_wb_addr = 4'd3; emo_wb_sel = WB_ALU; emo_alu = 16'h4321;
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd3};
        expect_o("reset_mid_wait", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        next_cyc();
        rst = 1'b1; idle();
        expect_o("after_reset_clear", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Memory ready immediately: no hold
        next_cyc(); idle();
        emo_mem_req = 1'b1; mem_ready = 1'b1;
        expect_o("mem_ready_no_hold", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);

        // R0 is forwarded when ZERO_REG_EN=0
        next_cyc(); idle();
        emo_wb_en = 1'b1; emo_wb_addr = 4'd0; emo_wb_sel = WB_ALU; emo_alu = 16'h0BAD;
        rd_valid = 2'b10; rd_addr = {4'd0, 4'd0};
        expect_o("r0_forward", 2'b10, 32'h0BAD_0000, 1'b0, 1'b0, 1'b0, 16'd0);

        // NOP selector is never a source
        next_cyc(); idle();
        emo_wb_en = 1'b1; emo_wb_addr = 4'd4; emo_wb_sel = WB_NOP; emo_alu = 16'h5A5A;
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd4};
        expect_o("nop_not_live", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Drain scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
